// File: rtl/framebuffer_reader_pkg.sv
// rtl/framebuffer_reader_pkg.sv - shared colour constants, pixel beat type and reader FSM states
package framebuffer_reader_pkg;

    localparam int COLOR_WIDTH = 8;
    localparam logic [COLOR_WIDTH-1:0] COLOR_NONE  = 8'h00;
    localparam logic [COLOR_WIDTH-1:0] COLOR_GREEN = 8'h1C;

    // One RAM read stage between issue and data return.
    localparam int FB_READ_LATENCY = 1;

    // Coordinate fields are sized for the largest supported frame; users keep the low bits.
    localparam int FB_COORD_W = 16;

    typedef struct packed {
        logic [COLOR_WIDTH-1:0] color;
        logic [FB_COORD_W-1:0]  x;
        logic [FB_COORD_W-1:0]  y;
        logic                   sof;
        logic                   eof;
    } fb_pixel_t;

    localparam fb_pixel_t FB_PIXEL_RESET = '{
        color: COLOR_NONE,
        x:     '0,
        y:     '0,
        sof:   1'b0,
        eof:   1'b0
    };

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2
    } fb_state_t;

endpackage

// File: rtl/framebuffer_reader_if.sv
// rtl/framebuffer_reader_if.sv - RAM read port and pixel output stream of the framebuffer reader
interface framebuffer_reader_if #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480
);
    import framebuffer_reader_pkg::*;

    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);
    localparam int AW = $clog2(WIDTH * HEIGHT);

    logic                   mem_rd_en;
    logic [AW-1:0]          mem_addr;
    logic [COLOR_WIDTH-1:0] mem_rd_data;

    logic                   out_valid;
    logic                   out_ready;
    logic [COLOR_WIDTH-1:0] out_color;
    logic [XW-1:0]          out_x;
    logic [YW-1:0]          out_y;
    logic                   out_sof;
    logic                   out_eof;

    modport master (
        output mem_rd_en, mem_addr,
        input  mem_rd_data,
        output out_valid, out_color, out_x, out_y, out_sof, out_eof,
        input  out_ready
    );

    modport slave (
        input  mem_rd_en, mem_addr,
        output mem_rd_data,
        input  out_valid, out_color, out_x, out_y, out_sof, out_eof,
        output out_ready
    );

endinterface

// File: rtl/framebuffer_reader_pixel_skid_fifo.sv
// rtl/framebuffer_reader_pixel_skid_fifo.sv - two-entry skid FIFO of pixel beats
module pixel_skid_fifo
    import framebuffer_reader_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       push,
    input  fb_pixel_t  push_data,
    input  logic       pop,
    output fb_pixel_t  head,
    output logic       valid,
    output logic [1:0] count
);

    fb_pixel_t  mem_q [2];
    fb_pixel_t  mem_d [2];
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] count_q, count_d;

    // Pointer/occupancy update; a push into a full FIFO only happens alongside a pop of the same slot.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q ^ push;
        rd_ptr_d = rd_ptr_q ^ pop;
        count_d  = count_q + {1'b0, push} - {1'b0, pop};
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
        end
    end

    // Storage and pointer registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_q[0] <= FB_PIXEL_RESET;
            mem_q[1] <= FB_PIXEL_RESET;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign valid = (count_q != 2'd0);
    assign count = count_q;

endmodule

// File: rtl/framebuffer_reader.sv
// rtl/framebuffer_reader.sv - row-major framebuffer scan-out; cursor overlay under FRAMEBUFFER_READER_CURSOR_EN
module framebuffer_reader
    import framebuffer_reader_pkg::*;
#(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       enable,
    input  logic [$clog2(WIDTH)-1:0]   cursor_x,
    input  logic [$clog2(HEIGHT)-1:0]  cursor_y,
    input  logic [COLOR_WIDTH-1:0]     cursor_color,
    output logic                       busy,
    output logic                       frame_done,
    framebuffer_reader_if.master       bus
);

    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);
    localparam int AW = $clog2(WIDTH * HEIGHT);
    localparam int FIFO_DEPTH = FB_READ_LATENCY + 1;
    localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

    fb_state_t     state_q, state_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          inflight_q, inflight_d;
    logic [XW-1:0] tag_x_q, tag_x_d;
    logic [YW-1:0] tag_y_q, tag_y_d;
    logic          tag_sof_q, tag_sof_d;
    logic          tag_eof_q, tag_eof_d;
    logic          frame_done_q, frame_done_d;

    fb_pixel_t     push_data;
    fb_pixel_t     head;
    logic          fifo_valid;
    logic [1:0]    fifo_count;
    logic          pop;
    logic          issue;
    logic          drained;
    logic          last_pix;

    // Pop credit lets a read issue in the same cycle a held beat is accepted.
    assign pop      = fifo_valid & bus.out_ready;
    assign issue    = (state_q == ST_SCAN) &&
                      (({1'b0, fifo_count} + {2'b0, inflight_q}) < (3'(FIFO_DEPTH) + {2'b0, pop}));
    assign drained  = (({1'b0, fifo_count} + {2'b0, inflight_q} - {2'b0, pop}) == 3'd0);
    assign last_pix = (x_q == X_LAST) && (y_q == Y_LAST);

`ifdef FRAMEBUFFER_READER_CURSOR_EN
    logic [XW-1:0]          cur_x_q, cur_x_d;
    logic [YW-1:0]          cur_y_q, cur_y_d;
    logic [COLOR_WIDTH-1:0] cur_color_q, cur_color_d;

    // Cursor is snapshotted at frame start so a moving cursor cannot tear mid-frame.
    always_comb begin
        cur_x_d     = cur_x_q;
        cur_y_d     = cur_y_q;
        cur_color_d = cur_color_q;
        if (state_q == ST_IDLE && enable) begin
            cur_x_d     = cursor_x;
            cur_y_d     = cursor_y;
            cur_color_d = cursor_color;
        end
    end

    // Cursor snapshot registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur_x_q     <= '0;
            cur_y_q     <= '0;
            cur_color_q <= COLOR_NONE;
        end else begin
            cur_x_q     <= cur_x_d;
            cur_y_q     <= cur_y_d;
            cur_color_q <= cur_color_d;
        end
    end
`else
    logic unused_cursor;
    assign unused_cursor = ^{cursor_x, cursor_y, cursor_color};
`endif

    // Returning RAM data joins its tag here; the cursor substitution happens at push so latency is unchanged.
    always_comb begin
        push_data       = FB_PIXEL_RESET;
        push_data.color = bus.mem_rd_data;
        push_data.x     = FB_COORD_W'(tag_x_q);
        push_data.y     = FB_COORD_W'(tag_y_q);
        push_data.sof   = tag_sof_q;
        push_data.eof   = tag_eof_q;
`ifdef FRAMEBUFFER_READER_CURSOR_EN
        if (tag_x_q == cur_x_q && tag_y_q == cur_y_q && cur_color_q != COLOR_NONE) begin
            push_data.color = cur_color_q;
        end
`endif
    end

    // Scan FSM next state: counters advance per issued read, frame_done fires when the last beat leaves.
    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        addr_d       = addr_q;
        inflight_d   = issue;
        tag_x_d      = tag_x_q;
        tag_y_d      = tag_y_q;
        tag_sof_d    = tag_sof_q;
        tag_eof_d    = tag_eof_q;
        frame_done_d = 1'b0;
        if (issue) begin
            tag_x_d   = x_q;
            tag_y_d   = y_q;
            tag_sof_d = (x_q == '0) && (y_q == '0);
            tag_eof_d = last_pix;
        end
        unique case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_SCAN;
                    x_d     = '0;
                    y_d     = '0;
                    addr_d  = '0;
                end
            end
            ST_SCAN: begin
                if (issue) begin
                    addr_d = addr_q + AW'(1);
                    if (x_q == X_LAST) begin
                        x_d = '0;
                        y_d = y_q + YW'(1);
                    end else begin
                        x_d = x_q + XW'(1);
                    end
                    if (last_pix) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (drained) begin
                    frame_done_d = 1'b1;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Scan FSM and read-tag pipeline registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            x_q          <= '0;
            y_q          <= '0;
            addr_q       <= '0;
            inflight_q   <= 1'b0;
            tag_x_q      <= '0;
            tag_y_q      <= '0;
            tag_sof_q    <= 1'b0;
            tag_eof_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            addr_q       <= addr_d;
            inflight_q   <= inflight_d;
            tag_x_q      <= tag_x_d;
            tag_y_q      <= tag_y_d;
            tag_sof_q    <= tag_sof_d;
            tag_eof_q    <= tag_eof_d;
            frame_done_q <= frame_done_d;
        end
    end

    pixel_skid_fifo u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (inflight_q),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .valid     (fifo_valid),
        .count     (fifo_count)
    );

    logic unused_head;
    assign unused_head = ^{head.x[FB_COORD_W-1:XW], head.y[FB_COORD_W-1:YW]};

    assign bus.mem_rd_en = issue;
    assign bus.mem_addr  = addr_q;
    assign bus.out_valid = fifo_valid;
    assign bus.out_color = head.color;
    assign bus.out_x     = head.x[XW-1:0];
    assign bus.out_y     = head.y[YW-1:0];
    assign bus.out_sof   = head.sof;
    assign bus.out_eof   = head.eof;
    assign busy          = (state_q != ST_IDLE);
    assign frame_done    = frame_done_q;

endmodule

// File: tb/tb_framebuffer_reader.sv
// tb/tb_framebuffer_reader.sv - scoreboard bench for framebuffer_reader on a 4x2 frame
module tb_framebuffer_reader;
    import framebuffer_reader_pkg::*;

    localparam int W = 4;
    localparam int H = 2;
    localparam int NPIX = W * H;

    typedef struct {
        logic [7:0] color;
        int         x;
        int         y;
        logic       sof;
        logic       eof;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic enable = 1'b0;
    logic [1:0] cursor_x = '0;
    logic [0:0] cursor_y = '0;
    logic [7:0] cursor_color = COLOR_NONE;
    logic busy;
    logic frame_done;
    logic [7:0] ram_q = '0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int sof_cyc = 0;
    int eof_cyc = 0;
    bit mon_en = 1'b0;
    exp_t sb[$];

    framebuffer_reader_if #(.WIDTH(W), .HEIGHT(H)) bus ();

    framebuffer_reader #(.WIDTH(W), .HEIGHT(H)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .cursor_x     (cursor_x),
        .cursor_y     (cursor_y),
        .cursor_color (cursor_color),
        .busy         (busy),
        .frame_done   (frame_done),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (bus.mem_rd_en) ram_q <= 8'(bus.mem_addr) + 8'd1;
    end
    assign bus.mem_rd_data = ram_q;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push_frame(input int cur_idx, input logic [7:0] cur_col);
        for (int i = 0; i < NPIX; i++) begin
            exp_t e;
            e.color = 8'(i + 1);
            if (i == cur_idx) e.color = cur_col;
            e.x   = i % W;
            e.y   = i / W;
            e.sof = (i == 0);
            e.eof = (i == NPIX - 1);
            sb.push_back(e);
        end
    endtask

    task automatic wait_done(output int done_cyc);
        bit found = 1'b0;
        done_cyc = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (frame_done) begin
                done_cyc = cyc;
                found = 1'b1;
                break;
            end
        end
        if (!found) check_eq("done_timeout", 0, 1);
    endtask

    task automatic wait_head(input int x, input int y);
        bit found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid && int'(bus.out_x) == x && int'(bus.out_y) == y) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) check_eq("head_timeout", 0, 1);
    endtask

    // Scoreboard monitor: every accepted beat must match the oldest expected one.
    always @(negedge clk) begin
        if (mon_en && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                check_eq("unexpected_beat", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_eq("beat_color", 32'(bus.out_color), 32'(e.color));
                check_eq("beat_x", 32'(bus.out_x), 32'(e.x));
                check_eq("beat_y", 32'(bus.out_y), 32'(e.y));
                check_eq("beat_sof", 32'(bus.out_sof), 32'(e.sof));
                check_eq("beat_eof", 32'(bus.out_eof), 32'(e.eof));
                if (bus.out_sof) sof_cyc = cyc;
                if (bus.out_eof) eof_cyc = cyc;
            end
        end
    end

    initial begin
        int start;
        int d1;
        int d2;
        bus.out_ready = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_rd_en", 32'(bus.mem_rd_en), 0);
        check_eq("rst_addr", 32'(bus.mem_addr), 0);
        check_eq("rst_valid", 32'(bus.out_valid), 0);
        check_eq("rst_color", 32'(bus.out_color), 32'(COLOR_NONE));
        check_eq("rst_xy", {30'b0, bus.out_x} | 32'(bus.out_y), 0);
        check_eq("rst_sof_eof", {30'b0, bus.out_sof, bus.out_eof}, 0);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_done", 32'(frame_done), 0);
        reset_n = 1'b1;
        bus.out_ready = 1'b1;
        mon_en = 1'b1;

        // Full frame, no backpressure
        @(posedge clk); #1;
        enable = 1'b1;
        push_frame(-1, 8'h00);
        @(posedge clk); #1;
        start = cyc;
        enable = 1'b0;
        check_eq("first_rd_en", 32'(bus.mem_rd_en), 1);
        check_eq("first_addr", 32'(bus.mem_addr), 0);
        check_eq("first_busy", 32'(busy), 1);
        wait_done(d1);
        check_eq("first_beat_latency", 32'(sof_cyc - start), 2);
        check_eq("frame_span", 32'(eof_cyc - sof_cyc), 7);
        check_eq("done_after_eof", 32'(d1 - eof_cyc), 1);
        check_eq("done_busy", 32'(busy), 0);
        check_eq("sb_empty_1", 32'(sb.size()), 0);

        // Backpressure at pixel 2
        @(posedge clk); #1;
        enable = 1'b1;
        push_frame(-1, 8'h00);
        @(posedge clk); #1;
        enable = 1'b0;
        wait_head(2, 0);
        bus.out_ready = 1'b0;
        #1;
        check_eq("stall_rd_en_0", 32'(bus.mem_rd_en), 0);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check_eq("stall_valid", 32'(bus.out_valid), 1);
            check_eq("stall_x", 32'(bus.out_x), 2);
            check_eq("stall_color", 32'(bus.out_color), 3);
            check_eq("stall_rd_en", 32'(bus.mem_rd_en), 0);
        end
        bus.out_ready = 1'b1;
        #1;
        check_eq("resume_rd_en", 32'(bus.mem_rd_en), 1);
        wait_done(d1);
        check_eq("sb_empty_stall", 32'(sb.size()), 0);

        // Enable dropped two cycles into the frame
        @(posedge clk); #1;
        enable = 1'b1;
        push_frame(-1, 8'h00);
        repeat (2) begin
            @(posedge clk); #1;
        end
        enable = 1'b0;
        wait_done(d1);
        repeat (3) @(posedge clk);
        #1;
        check_eq("drop_busy", 32'(busy), 0);
        check_eq("drop_rd_en", 32'(bus.mem_rd_en), 0);
        check_eq("sb_empty_drop", 32'(sb.size()), 0);

        // Reset mid-frame at beat 4
        enable = 1'b1;
        push_frame(-1, 8'h00);
        @(posedge clk); #1;
        enable = 1'b0;
        wait_head(0, 1);
        mon_en = 1'b0;
        reset_n = 1'b0;
        #1;
        check_eq("midrst_valid", 32'(bus.out_valid), 0);
        check_eq("midrst_rd_en", 32'(bus.mem_rd_en), 0);
        check_eq("midrst_busy", 32'(busy), 0);
        sb.delete();
        @(posedge clk); #1;
        reset_n = 1'b1;
        enable = 1'b1;
        push_frame(-1, 8'h00);
        mon_en = 1'b1;
        @(posedge clk); #1;
        enable = 1'b0;
        check_eq("restart_rd_en", 32'(bus.mem_rd_en), 1);
        check_eq("restart_addr", 32'(bus.mem_addr), 0);
        wait_done(d1);
        check_eq("sb_empty_rst", 32'(sb.size()), 0);

        // Cursor overlay at (2,1)
        @(posedge clk); #1;
        cursor_x = 2'd2;
        cursor_y = 1'd1;
        cursor_color = COLOR_GREEN;
        enable = 1'b1;
`ifdef FRAMEBUFFER_READER_CURSOR_EN
        push_frame(6, COLOR_GREEN);
`else
        push_frame(-1, 8'h00);
`endif
        @(posedge clk); #1;
        enable = 1'b0;
        cursor_color = 8'h55;
        wait_done(d1);
        @(posedge clk); #1;
        cursor_color = COLOR_NONE;
        enable = 1'b1;
        push_frame(-1, 8'h00);
        @(posedge clk); #1;
        enable = 1'b0;
        wait_done(d1);
        check_eq("sb_empty_cursor", 32'(sb.size()), 0);

        // Back-to-back frames with enable held
        @(posedge clk); #1;
        enable = 1'b1;
        push_frame(-1, 8'h00);
        push_frame(-1, 8'h00);
        wait_done(d1);
        check_eq("b2b_gap_rd_en", 32'(bus.mem_rd_en), 0);
        check_eq("b2b_gap_busy", 32'(busy), 0);
        @(negedge clk);
        check_eq("b2b_next_rd_en", 32'(bus.mem_rd_en), 1);
        check_eq("b2b_next_addr", 32'(bus.mem_addr), 0);
        wait_done(d2);
        enable = 1'b0;
        check_eq("b2b_period", 32'(d2 - d1), 11);
        repeat (3) @(posedge clk);
        #1;
        check_eq("sb_empty_b2b", 32'(sb.size()), 0);
        check_eq("final_busy", 32'(busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
